// File: rtl/fft_pkg.sv
// Constants shared by the 32-point SDF FFT pipeline (delay lines, butterflies, output reorder).
package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int FFT_WIDTH = 15;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] a);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < FFT_LOG2N; i++) begin
      r[i] = a[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle around the reorder buffer: producer side in, consumer side out with valid/ready.
interface fft_bitrev_reorder_if
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_r;
  logic [WIDTH-1:0] in_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_i;
  logic             out_last;
  logic             overflow;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  out_valid, out_r, out_i, out_last, overflow
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output out_valid, out_r, out_i, out_last, overflow
  );

endinterface

// File: rtl/fft_pingpong_bank.sv
// One frame of complex samples: synchronous write port, asynchronous read port, no reset on storage.
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW    = 2 * FFT_WIDTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order and leave in natural order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int WIDTH = FFT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_bitrev_reorder_if.slave  bus
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;
  logic             wbank;
  logic             rbank;
  logic [1:0]       full;
  logic             overflow;

  logic             wr_ok;
  logic             wr_done;
  logic             rd_fire;
  logic             rd_done;
  logic [LOG2N-1:0] waddr;
  logic [2*WIDTH-1:0] wdata;
  logic [2*WIDTH-1:0] rdata [2];
  logic [2*WIDTH-1:0] rsel;

  // The write-side check uses the registered flag, so a bank freed this cycle still rejects input.
  assign wr_ok   = bus.in_valid && !full[wbank];
  assign wr_done = wr_ok && (wcnt == LAST);
  assign rd_fire = full[rbank] && bus.out_ready;
  assign rd_done = rd_fire && (rcnt == LAST);
  assign waddr   = bitrev(wcnt);
  assign wdata   = {bus.in_r, bus.in_i};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_pingpong_bank #(
      .N     (N),
      .LOG2N (LOG2N),
      .DW    (2 * WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (wr_ok && (wbank == 1'(b))),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rcnt),
      .rdata (rdata[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST) begin
          wbank <= ~wbank;
        end
      end
      if (bus.in_valid && full[wbank]) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt  <= '0;
      rbank <= 1'b0;
    end else if (rd_fire) begin
      rcnt <= rcnt + 1'b1;
      if (rcnt == LAST) begin
        rbank <= ~rbank;
      end
    end
  end

  // A completing write and a completing read always target different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (rd_done) begin
        full[rbank] <= 1'b0;
      end
      if (wr_done) begin
        full[wbank] <= 1'b1;
      end
    end
  end

  // Gate data with valid so outputs are deterministic zero while no frame is ready.
  assign rsel          = rdata[rbank];
  assign bus.out_valid = full[rbank];
  assign bus.out_r     = full[rbank] ? rsel[2*WIDTH-1:WIDTH] : '0;
  assign bus.out_i     = full[rbank] ? rsel[WIDTH-1:0] : '0;
  assign bus.out_last  = full[rbank] && (rcnt == LAST);
  assign bus.overflow  = overflow;

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder buffer for the 32-point SDF FFT pipeline.
- The last butterfly stage emits each frame in bit-reversed index order.
- This block collects each frame into one of two ping-pong banks at bit-reversed addresses, then streams it out in natural order with a valid/ready handshake.
- Sits between the final FFT stage (including its delay-line stages) and the downstream consumer.

Parameters:
- N, 32, points per frame; must be a power of two.
- LOG2N, 5, log2(N); address and counter width.
- WIDTH, 15, bit width of each real and imaginary component.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  one FFT output sample is present this cycle; the producer never stalls.
- in_r  input  WIDTH  real part, bit-reversed order.
- in_i  input  WIDTH  imaginary part, bit-reversed order.
- out_valid  output  1  out_r/out_i hold a valid sample.
- out_ready  input  1  consumer accepts the sample this cycle.
- out_r  output  WIDTH  real part, natural order.
- out_i  output  WIDTH  imaginary part, natural order.
- out_last  output  1  high with out_valid on sample index N-1 of a frame.
- overflow  output  1  sticky: an input sample was dropped.

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. Reset state:
  - wcnt=0, rcnt=0, wbank=0, rbank=0, full[1:0]=0, overflow=0.
  - out_valid=0, out_last=0, out_r=0, out_i=0.
  - Memory contents are don't-care.
- Storage: two banks of N complex entries, i.e. mem[bank][addr] of width 2*WIDTH.
- Write side, on each cycle with in_valid=1:
  - If full[wbank]=0: write {in_r,in_i} to mem[wbank][bitrev(wcnt)], where bitrev reverses LOG2N bits, then increment wcnt mod N.
  - When the write lands with wcnt==N-1: set full[wbank] and toggle wbank.
  - If full[wbank]=1: drop the sample, set overflow=1 (held until reset), leave wcnt and wbank unchanged.
- Read side:
  - out_valid = full[rbank].
  - out_r/out_i = mem[rbank][rcnt], read combinationally from the register array.
  - out_last = out_valid && (rcnt==N-1).
  - On out_valid && out_ready: increment rcnt mod N.
  - If that transfer had rcnt==N-1: clear full[rbank] and toggle rbank.
  - With out_valid=1 and out_ready=0, out_r/out_i/out_last hold stable.
- Simultaneous events:
  - A write completing a frame and a read completing a frame in the same cycle operate on different banks; both take effect.
  - A read clearing full[b] in the same cycle in_valid targets bank b: the write uses the pre-clear flag, so the sample is dropped and overflow is set. Under continuous in_valid with out_ready=1 this cannot occur, because a bank drains 32 cycles after it fills.
- Latency: out_valid rises the cycle after the write of input sample N-1 of a frame. Sample 0 of that frame appears then.
- Throughput: one sample per cycle sustained when out_ready=1.
- Reset mid-frame discards partial frames in both banks; no output follows until a full new frame has been written.
- No arithmetic: data pass through unmodified, bit-exact.

Decomposition:
- Shared package fft_pkg holds FFT_N=32, FFT_LOG2N=5, FFT_WIDTH=15 and a bitrev function of width LOG2N. The same constants are used by the delay-line and butterfly stages.
- One natural sub-module: fft_pingpong_bank, one N x 2*WIDTH register bank with a synchronous write port and an asynchronous read port, instantiated twice.

Test Plan:
- Reset: hold rst_n=0, drive in_valid=1 -> out_valid=0, overflow=0, out_r=0. Release; no output until 32 valid inputs are written.
- Single frame: in_r=k, in_i=-k for k=0..31, consecutive cycles, out_ready=1 -> output j carries in_r=bitrev5(j), giving sequence 0,16,8,24,4,20,...,31. out_valid rises the cycle after k=31. out_last only on the 32nd output.
- Back-to-back: 4 frames with continuous in_valid, out_ready=1 -> 128 outputs, no gaps after the first, overflow stays 0.
- Backpressure: out_ready toggling 1,0,0,1 during a frame -> data and out_last stable while stalled, order preserved, no duplicates.
- Overflow: out_ready=0, feed 3 full frames -> the first 64 samples are stored and the third frame is dropped; overflow=1 from the first sample of frame 3. With out_ready=1 afterwards, exactly frames 1 and 2 are output correctly.
- Mid-frame reset: assert rst_n=0 after 10 inputs of frame 2 while frame 1 is draining -> all outputs drop to 0 immediately. A new frame afterwards is reordered correctly.
